// File: rtl/dc_bank_scheduler.sv
// dc_bank_scheduler: single-issue arbiter in front of the 8-bank L1 data array.
// Fill, load and store-data requesters compete for one registered bank request
// port. The scheduler enforces a per-bank recovery time, caps outstanding reads
// and passes read acks back to the load port.
//
// Handshake: a transfer happens on valid & !retry. A requester's retry is high
// in every cycle it is not granted, including while it is idle and during reset.
module dc_bank_scheduler #(
   parameter int DATA_W   = 36,
   parameter int IDX_W    = 5,
   parameter int BUSY_CYC = 2,
   parameter int RD_MAX   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fill_req_valid,
   output logic              fill_req_retry,
   input  logic [2:0]        fill_req_bank,
   input  logic [2:0]        fill_req_way,
   input  logic [IDX_W-1:0]  fill_req_index,
   input  logic [DATA_W-1:0] fill_req_data,
   input  logic              ld_req_valid,
   output logic              ld_req_retry,
   input  logic [2:0]        ld_req_bank,
   input  logic [2:0]        ld_req_way,
   input  logic [IDX_W-1:0]  ld_req_index,
   input  logic              st_req_valid,
   output logic              st_req_retry,
   input  logic [2:0]        st_req_bank,
   input  logic [2:0]        st_req_way,
   input  logic [IDX_W-1:0]  st_req_index,
   input  logic [DATA_W-1:0] st_req_data,
   output logic              bk_req_valid,
   input  logic              bk_req_retry,
   output logic              bk_write,
   output logic [2:0]        bk_bank_sel,
   output logic [2:0]        bk_way,
   output logic [IDX_W-1:0]  bk_index,
   output logic [DATA_W-1:0] bk_data,
   input  logic              bk_ack_valid,
   input  logic [DATA_W-1:0] bk_ack_data,
   output logic              bk_ack_retry,
   output logic              ld_ack_valid,
   output logic [DATA_W-1:0] ld_ack_data,
   input  logic              ld_ack_retry,
   output logic              err_ack_underflow
);

   localparam int BW = (BUSY_CYC > 0) ? $clog2(BUSY_CYC + 1) : 1;
   localparam int CW = $clog2(RD_MAX + 1);

   logic [BW-1:0]     busy_cnt [8];
   logic [CW-1:0]     rd_cnt;
   logic              rr_last;   // 0 = load granted last, 1 = store granted last

   logic              issue_free;
   logic              fill_elig, ld_elig, st_elig;
   logic              gnt_fill, gnt_ld, gnt_st, gnt_any;
   logic [2:0]        gnt_bank;
   logic [2:0]        gnt_way;
   logic [IDX_W-1:0]  gnt_index;
   logic [DATA_W-1:0] gnt_data;
   logic              ack_xfer;

   // Issue register can take a new request when empty or when it is draining this cycle.
   assign issue_free = !bk_req_valid || !bk_req_retry;

   assign fill_elig = fill_req_valid && (busy_cnt[fill_req_bank] == '0);
   assign ld_elig   = ld_req_valid && (busy_cnt[ld_req_bank] == '0) && (rd_cnt < CW'(RD_MAX));
   assign st_elig   = st_req_valid && (busy_cnt[st_req_bank] == '0);

   // Pick at most one winner: fill first, then load/store round-robin.
   always_comb begin
      gnt_fill = 1'b0;
      gnt_ld   = 1'b0;
      gnt_st   = 1'b0;
      if (!reset && issue_free) begin
         if (fill_elig) begin
            gnt_fill = 1'b1;
         end else if (ld_elig && st_elig) begin
            if (rr_last) gnt_ld = 1'b1;
            else         gnt_st = 1'b1;
         end else if (ld_elig) begin
            gnt_ld = 1'b1;
         end else if (st_elig) begin
            gnt_st = 1'b1;
         end
      end
   end

   assign gnt_any = gnt_fill || gnt_ld || gnt_st;

   // Mux the winning request's fields; reads carry zero data.
   always_comb begin
      gnt_bank  = '0;
      gnt_way   = '0;
      gnt_index = '0;
      gnt_data  = '0;
      if (gnt_fill) begin
         gnt_bank  = fill_req_bank;
         gnt_way   = fill_req_way;
         gnt_index = fill_req_index;
         gnt_data  = fill_req_data;
      end else if (gnt_ld) begin
         gnt_bank  = ld_req_bank;
         gnt_way   = ld_req_way;
         gnt_index = ld_req_index;
      end else if (gnt_st) begin
         gnt_bank  = st_req_bank;
         gnt_way   = st_req_way;
         gnt_index = st_req_index;
         gnt_data  = st_req_data;
      end
   end

   assign fill_req_retry = !gnt_fill;
   assign ld_req_retry   = !gnt_ld;
   assign st_req_retry   = !gnt_st;

   assign ld_ack_valid = bk_ack_valid && !reset;
   assign ld_ack_data  = bk_ack_data;
   assign bk_ack_retry = ld_ack_retry;
   assign ack_xfer     = ld_ack_valid && !ld_ack_retry;

   // Issue register: load on grant, drop valid once accepted, hold while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         bk_req_valid <= 1'b0;
         bk_write     <= 1'b0;
         bk_bank_sel  <= '0;
         bk_way       <= '0;
         bk_index     <= '0;
         bk_data      <= '0;
      end else if (gnt_any) begin
         bk_req_valid <= 1'b1;
         bk_write     <= !gnt_ld;
         bk_bank_sel  <= gnt_bank;
         bk_way       <= gnt_way;
         bk_index     <= gnt_index;
         bk_data      <= gnt_data;
      end else if (issue_free) begin
         bk_req_valid <= 1'b0;
      end
   end

   // Per-bank recovery counters: reload on grant, otherwise count down to zero.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (reset) begin
            busy_cnt[b] <= '0;
         end else if (gnt_any && (gnt_bank == 3'(b))) begin
            busy_cnt[b] <= BW'(BUSY_CYC);
         end else if (busy_cnt[b] != '0) begin
            busy_cnt[b] <= busy_cnt[b] - 1'b1;
         end
      end
   end

   // Round-robin pointer moves only on load or store grants.
   always_ff @(posedge clk) begin
      if (reset)       rr_last <= 1'b1;
      else if (gnt_ld) rr_last <= 1'b0;
      else if (gnt_st) rr_last <= 1'b1;
   end

   // Outstanding-read counter and sticky underflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_cnt            <= '0;
         err_ack_underflow <= 1'b0;
      end else begin
         if (ack_xfer && (rd_cnt == '0)) err_ack_underflow <= 1'b1;
         if (gnt_ld && !ack_xfer) begin
            rd_cnt <= rd_cnt + 1'b1;
         end else if (!gnt_ld && ack_xfer && (rd_cnt != '0)) begin
            rd_cnt <= rd_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dc_bank_scheduler.sv
// Directed bench for dc_bank_scheduler. Instance dut uses BUSY_CYC=2; instance
// dut0 uses BUSY_CYC=0 for the load/store alternation case. Both share inputs.
module tb_dc_bank_scheduler;

   localparam int DATA_W = 36;
   localparam int IDX_W  = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              fill_req_valid, ld_req_valid, st_req_valid;
   logic [2:0]        fill_req_bank, fill_req_way, ld_req_bank, ld_req_way, st_req_bank, st_req_way;
   logic [IDX_W-1:0]  fill_req_index, ld_req_index, st_req_index;
   logic [DATA_W-1:0] fill_req_data, st_req_data, bk_ack_data;
   logic              bk_req_retry, bk_ack_valid, ld_ack_retry;

   logic              fill_req_retry, ld_req_retry, st_req_retry;
   logic              bk_req_valid, bk_write, bk_ack_retry, ld_ack_valid, err_ack_underflow;
   logic [2:0]        bk_bank_sel, bk_way;
   logic [IDX_W-1:0]  bk_index;
   logic [DATA_W-1:0] bk_data, ld_ack_data;

   logic              z_fill_req_retry, z_ld_req_retry, z_st_req_retry;
   logic              z_bk_req_valid, z_bk_write, z_bk_ack_retry, z_ld_ack_valid, z_err;
   logic [2:0]        z_bk_bank_sel, z_bk_way;
   logic [IDX_W-1:0]  z_bk_index;
   logic [DATA_W-1:0] z_bk_data, z_ld_ack_data;

   int checks = 0;
   int errors = 0;
   logic [0:0] exp_q[$];

   dc_bank_scheduler #(.DATA_W(DATA_W), .IDX_W(IDX_W), .BUSY_CYC(2), .RD_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .fill_req_valid(fill_req_valid), .fill_req_retry(fill_req_retry),
      .fill_req_bank(fill_req_bank), .fill_req_way(fill_req_way),
      .fill_req_index(fill_req_index), .fill_req_data(fill_req_data),
      .ld_req_valid(ld_req_valid), .ld_req_retry(ld_req_retry),
      .ld_req_bank(ld_req_bank), .ld_req_way(ld_req_way), .ld_req_index(ld_req_index),
      .st_req_valid(st_req_valid), .st_req_retry(st_req_retry),
      .st_req_bank(st_req_bank), .st_req_way(st_req_way),
      .st_req_index(st_req_index), .st_req_data(st_req_data),
      .bk_req_valid(bk_req_valid), .bk_req_retry(bk_req_retry), .bk_write(bk_write),
      .bk_bank_sel(bk_bank_sel), .bk_way(bk_way), .bk_index(bk_index), .bk_data(bk_data),
      .bk_ack_valid(bk_ack_valid), .bk_ack_data(bk_ack_data), .bk_ack_retry(bk_ack_retry),
      .ld_ack_valid(ld_ack_valid), .ld_ack_data(ld_ack_data), .ld_ack_retry(ld_ack_retry),
      .err_ack_underflow(err_ack_underflow)
   );

   dc_bank_scheduler #(.DATA_W(DATA_W), .IDX_W(IDX_W), .BUSY_CYC(0), .RD_MAX(4)) dut0 (
      .clk(clk), .reset(reset),
      .fill_req_valid(fill_req_valid), .fill_req_retry(z_fill_req_retry),
      .fill_req_bank(fill_req_bank), .fill_req_way(fill_req_way),
      .fill_req_index(fill_req_index), .fill_req_data(fill_req_data),
      .ld_req_valid(ld_req_valid), .ld_req_retry(z_ld_req_retry),
      .ld_req_bank(ld_req_bank), .ld_req_way(ld_req_way), .ld_req_index(ld_req_index),
      .st_req_valid(st_req_valid), .st_req_retry(z_st_req_retry),
      .st_req_bank(st_req_bank), .st_req_way(st_req_way),
      .st_req_index(st_req_index), .st_req_data(st_req_data),
      .bk_req_valid(z_bk_req_valid), .bk_req_retry(bk_req_retry), .bk_write(z_bk_write),
      .bk_bank_sel(z_bk_bank_sel), .bk_way(z_bk_way), .bk_index(z_bk_index), .bk_data(z_bk_data),
      .bk_ack_valid(bk_ack_valid), .bk_ack_data(bk_ack_data), .bk_ack_retry(z_bk_ack_retry),
      .ld_ack_valid(z_ld_ack_valid), .ld_ack_data(z_ld_ack_data), .ld_ack_retry(ld_ack_retry),
      .err_ack_underflow(z_err)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fill_req_valid = 1'b0;
      ld_req_valid   = 1'b0;
      st_req_valid   = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      fill_req_valid = 1'b1; fill_req_bank = 3'd0; fill_req_way = 3'd0; fill_req_index = '0;
      fill_req_data = '0;
      ld_req_valid = 1'b1; ld_req_bank = 3'd0; ld_req_way = 3'd0; ld_req_index = '0;
      st_req_valid = 1'b1; st_req_bank = 3'd1; st_req_way = 3'd0; st_req_index = '0;
      st_req_data = '0;
      bk_req_retry = 1'b0; bk_ack_valid = 1'b1; bk_ack_data = '0; ld_ack_retry = 1'b0;

      // Reset: everything retried, no ack forwarded
      #1;
      check("rst_fill_retry", fill_req_retry, 1'b1);
      check("rst_ld_retry", ld_req_retry, 1'b1);
      check("rst_st_retry", st_req_retry, 1'b1);
      check("rst_ld_ack_valid", ld_ack_valid, 1'b0);
      step();
      step();
      reset = 1'b0; idle(); bk_ack_valid = 1'b0;
      check("rst_bk_req_valid", bk_req_valid, 1'b0);
      check("rst_rd_cnt", dut.rd_cnt, 0);
      check("rst_err", err_ack_underflow, 1'b0);

      // 1: single load bank 3 idx 5 way 2, then ack
      ld_req_valid = 1'b1; ld_req_bank = 3'd3; ld_req_way = 3'd2; ld_req_index = 5'd5;
      #1;
      check("t1_ld_retry", ld_req_retry, 1'b0);
      step();
      idle();
      check("t1_bk_valid", bk_req_valid, 1'b1);
      check("t1_bk_write", bk_write, 1'b0);
      check("t1_bk_bank", bk_bank_sel, 3'd3);
      check("t1_bk_way", bk_way, 3'd2);
      check("t1_bk_index", bk_index, 5'd5);
      check("t1_bk_data", bk_data, 0);
      check("t1_rd_cnt1", dut.rd_cnt, 1);
      step();
      check("t1_bk_valid_drop", bk_req_valid, 1'b0);
      bk_ack_valid = 1'b1; bk_ack_data = 36'h123456789;
      #1;
      check("t1_ack_valid", ld_ack_valid, 1'b1);
      check("t1_ack_data", ld_ack_data, 36'h123456789);
      step();
      bk_ack_valid = 1'b0;
      check("t1_rd_cnt0", dut.rd_cnt, 0);

      // 2: fill beats load, load granted next cycle
      fill_req_valid = 1'b1; fill_req_bank = 3'd0; fill_req_way = 3'd1; fill_req_index = 5'd9;
      fill_req_data = 36'hA5A5A5A5F;
      ld_req_valid = 1'b1; ld_req_bank = 3'd6; ld_req_way = 3'd4; ld_req_index = 5'd17;
      #1;
      check("t2_fill_retry", fill_req_retry, 1'b0);
      check("t2_ld_retry", ld_req_retry, 1'b1);
      step();
      fill_req_valid = 1'b0;
      check("t2_bk_write", bk_write, 1'b1);
      check("t2_bk_bank", bk_bank_sel, 3'd0);
      check("t2_bk_data", bk_data, 36'hA5A5A5A5F);
      #1;
      check("t2_ld_retry2", ld_req_retry, 1'b0);
      step();
      idle();
      check("t2_bk_ld_bank", bk_bank_sel, 3'd6);
      check("t2_bk_ld_write", bk_write, 1'b0);
      check("t2_rd_cnt1", dut.rd_cnt, 1);
      // stalled ack does not transfer
      bk_ack_valid = 1'b1; ld_ack_retry = 1'b1;
      #1;
      check("t2_bk_ack_retry", bk_ack_retry, 1'b1);
      step();
      check("t2_rd_cnt_hold", dut.rd_cnt, 1);
      ld_ack_retry = 1'b0;
      step();
      bk_ack_valid = 1'b0;
      check("t2_rd_cnt0", dut.rd_cnt, 0);
      for (int i = 0; i < 3; i++) step();

      // 4: bank recovery, store bank 1 then load bank 1
      st_req_valid = 1'b1; st_req_bank = 3'd1; st_req_way = 3'd3; st_req_index = 5'd2;
      st_req_data = 36'h0DEADBEEF;
      #1;
      check("t4_st_retry", st_req_retry, 1'b0);
      step();
      st_req_valid = 1'b0;
      ld_req_valid = 1'b1; ld_req_bank = 3'd1; ld_req_way = 3'd3; ld_req_index = 5'd2;
      check("t4_st_bk_data", bk_data, 36'h0DEADBEEF);
      #1;
      check("t4_ld_busy1", ld_req_retry, 1'b1);
      step();
      check("t4_ld_busy2", ld_req_retry, 1'b1);
      step();
      check("t4_ld_go", ld_req_retry, 1'b0);
      step();
      check("t4_bk_bank1", bk_bank_sel, 3'd1);
      ld_req_bank = 3'd4;
      #1;
      check("t4_ld_b4_go", ld_req_retry, 1'b0);
      step();
      idle();
      check("t4_bk_bank4", bk_bank_sel, 3'd4);
      check("t4_rd_cnt2", dut.rd_cnt, 2);
      bk_ack_valid = 1'b1;
      step();
      step();
      bk_ack_valid = 1'b0;
      check("t4_rd_cnt0", dut.rd_cnt, 0);
      for (int i = 0; i < 3; i++) step();

      // 5: read cap, then underflow
      ld_req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ld_req_bank = 3'(2 * i);
         #1;
         check("t5_ld_go", ld_req_retry, 1'b0);
         step();
      end
      ld_req_bank = 3'd7;
      #1;
      check("t5_cap_retry", ld_req_retry, 1'b1);
      check("t5_rd_cnt4", dut.rd_cnt, 4);
      step();
      check("t5_cap_retry2", ld_req_retry, 1'b1);
      bk_ack_valid = 1'b1;
      #1;
      check("t5_cap_retry3", ld_req_retry, 1'b1);
      step();
      bk_ack_valid = 1'b0;
      check("t5_rd_cnt3", dut.rd_cnt, 3);
      #1;
      check("t5_ld5_go", ld_req_retry, 1'b0);
      step();
      idle();
      check("t5_rd_cnt4b", dut.rd_cnt, 4);
      check("t5_bk_bank7", bk_bank_sel, 3'd7);
      bk_ack_valid = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check("t5_rd_cnt0", dut.rd_cnt, 0);
      check("t5_err0", err_ack_underflow, 1'b0);
      step();
      bk_ack_valid = 1'b0;
      check("t5_err1", err_ack_underflow, 1'b1);
      check("t5_rd_cnt_floor", dut.rd_cnt, 0);
      step();
      check("t5_err_sticky", err_ack_underflow, 1'b1);

      // 6: bank stall holds issue register; reset mid-hold drops it
      ld_req_valid = 1'b1; ld_req_bank = 3'd2; ld_req_way = 3'd5; ld_req_index = 5'd30;
      #1;
      check("t6_ld_go", ld_req_retry, 1'b0);
      step();
      bk_req_retry = 1'b1;
      ld_req_bank = 3'd6;
      fill_req_valid = 1'b1; fill_req_bank = 3'd5;
      st_req_valid = 1'b1; st_req_bank = 3'd3;
      check("t6_rd_cnt1", dut.rd_cnt, 1);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t6_hold_fill_retry", fill_req_retry, 1'b1);
         check("t6_hold_ld_retry", ld_req_retry, 1'b1);
         check("t6_hold_st_retry", st_req_retry, 1'b1);
         check("t6_hold_valid", bk_req_valid, 1'b1);
         check("t6_hold_bank", bk_bank_sel, 3'd2);
         check("t6_hold_way", bk_way, 3'd5);
         check("t6_hold_index", bk_index, 5'd30);
         step();
      end
      reset = 1'b1; bk_ack_valid = 1'b1;
      #1;
      check("t6_rst_ack_valid", ld_ack_valid, 1'b0);
      check("t6_rst_fill_retry", fill_req_retry, 1'b1);
      step();
      check("t6_rst_bk_valid", bk_req_valid, 1'b0);
      check("t6_rst_rd_cnt", dut.rd_cnt, 0);
      check("t6_rst_err", err_ack_underflow, 1'b0);
      reset = 1'b0; idle(); bk_req_retry = 1'b0; bk_ack_valid = 1'b0;

      // 3: BUSY_CYC=0 instance, load and store every cycle alternate L,S,...
      ld_req_valid = 1'b1; ld_req_bank = 3'd0;
      st_req_valid = 1'b1; st_req_bank = 3'd1;
      for (int i = 0; i < 6; i++) exp_q.push_back(1'(i % 2));
      for (int i = 0; i < 6; i++) begin
         step();
         check("t3_valid", z_bk_req_valid, 1'b1);
         check("t3_write_seq", z_bk_write, exp_q.pop_front());
      end
      idle();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
